// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: data1_i - data2_i, one DIGIT_WIDTH slice per cycle, LSB first,
// with valid/ready on both the operand and the result side.
module serial_subtractor #(
   parameter ARCHITECTURE     = "BEHAVIORAL",
   parameter int DATA_WIDTH_1 = 8,
   parameter int DATA_WIDTH_2 = 8,
   parameter int DIGIT_WIDTH  = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [DATA_WIDTH_1-1:0]  data1_i,
   input  logic [DATA_WIDTH_2-1:0]  data2_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [((DATA_WIDTH_1 > DATA_WIDTH_2) ? DATA_WIDTH_1 : DATA_WIDTH_2):0] data_o,
   output logic                     zero_o
);

   localparam int W     = (DATA_WIDTH_1 > DATA_WIDTH_2) ? DATA_WIDTH_1 : DATA_WIDTH_2;
   localparam int N     = W / DIGIT_WIDTH;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   if (W % DIGIT_WIDTH != 0) begin : g_bad_digit
      $error("serial_subtractor: DIGIT_WIDTH must divide max(DATA_WIDTH_1, DATA_WIDTH_2)");
   end

   // Only the behavioral datapath exists; any other selection falls back to it.
   if (ARCHITECTURE != "BEHAVIORAL") begin : g_arch_fallback
   end

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      HOLD
   } state_t;

   state_t                 state, state_nxt;
   logic [W-1:0]           a_q, b_q, res_q, res_nxt;
   logic                   borrow_q;
   logic [IDX_W-1:0]       idx_q;
   logic [DIGIT_WIDTH-1:0] a_dig, b_dig;
   logic [DIGIT_WIDTH:0]   diff;
   logic                   last;

   assign a_dig = a_q[idx_q*DIGIT_WIDTH +: DIGIT_WIDTH];
   assign b_dig = b_q[idx_q*DIGIT_WIDTH +: DIGIT_WIDTH];
   // The extra top bit of diff wraps to 1 exactly when this digit needs to borrow.
   assign diff  = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT_WIDTH{1'b0}}, borrow_q};
   assign last  = (idx_q == IDX_W'(N - 1));

   // Handshake outputs decode registered state only, so no input reaches an output combinationally.
   assign ready_o = (state == IDLE);
   assign valid_o = (state == HOLD);

   always_comb begin
      res_nxt = res_q;
      res_nxt[idx_q*DIGIT_WIDTH +: DIGIT_WIDTH] = diff[DIGIT_WIDTH-1:0];
   end

   // NOTE: every signal assigned in an always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (valid_i) state_nxt = CALC;
         CALC:    if (last)    state_nxt = HOLD;
         HOLD:    if (ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         idx_q    <= '0;
         data_o   <= '0;
         zero_o   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (valid_i) begin
                  a_q      <= W'(data1_i);
                  b_q      <= W'(data2_i);
                  borrow_q <= 1'b0;
                  idx_q    <= '0;
               end
            end
            CALC: begin
               res_q    <= res_nxt;
               borrow_q <= diff[DIGIT_WIDTH];
               idx_q    <= last ? '0 : idx_q + 1'b1;
               if (last) begin
                  data_o <= {diff[DIGIT_WIDTH], res_nxt};
                  zero_o <= (res_nxt == '0) && !diff[DIGIT_WIDTH];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, backpressure, mid-operation reset,
// and a mixed-width instance; expected results go through a scoreboard queue.
module tb_serial_subtractor;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       valid_i, ready_i;
   logic [7:0] data1_i, data2_i;
   logic       ready_o, valid_o, zero_o;
   logic [8:0] data_o;

   logic        valid_w_i, ready_w_i;
   logic [11:0] data1_w_i;
   logic [7:0]  data2_w_i;
   logic        ready_w_o, valid_w_o, zero_w_o;
   logic [12:0] data_w_o;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int hs_cyc = 0;
   logic [9:0] exp_q[$];

   serial_subtractor #(.DATA_WIDTH_1(8), .DATA_WIDTH_2(8), .DIGIT_WIDTH(4)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
      .data1_i(data1_i), .data2_i(data2_i), .valid_o(valid_o), .ready_i(ready_i),
      .data_o(data_o), .zero_o(zero_o)
   );

   serial_subtractor #(.DATA_WIDTH_1(12), .DATA_WIDTH_2(8), .DIGIT_WIDTH(4)) dut_w (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_w_i), .ready_o(ready_w_o),
      .data1_i(data1_w_i), .data2_i(data2_w_i), .valid_o(valid_w_o), .ready_i(ready_w_i),
      .data_o(data_w_o), .zero_o(zero_w_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Present operands, wait for acceptance, push the expected {zero, data}.
   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] d, input logic z, input bit gap);
      int t;
      t = 0;
      data1_i = a;
      data2_i = b;
      valid_i = 1'b1;
      while (ready_o !== 1'b1 && t < 64) begin
         @(negedge clk_i);
         t++;
      end
      check("accept_timeout", 32'(t < 64), 1);
      @(posedge clk_i);
      #1;
      acc_cyc = cyc;
      exp_q.push_back({z, d});
      if (gap) check("accept_after_handshake", acc_cyc - hs_cyc, 1);
      valid_i = 1'b0;
      data1_i = ~a;
      data2_i = ~b;
   endtask

   // Wait for the result, optionally stall it, then complete the handshake and compare.
   task automatic receive(input int stall);
      int t;
      logic [9:0] e;
      t = 0;
      @(negedge clk_i);
      while (valid_o !== 1'b1 && t < 64) begin
         @(negedge clk_i);
         t++;
      end
      check("result_timeout", 32'(t < 64), 1);
      check("latency", cyc - acc_cyc, 2);
      e = exp_q[0];
      ready_i = (stall == 0);
      for (int s = 0; s < stall; s++) begin
         valid_i = 1'b1;
         data1_i = 8'($urandom);
         data2_i = 8'($urandom);
         @(negedge clk_i);
         check("stall_data", data_o, e[8:0]);
         check("stall_zero", zero_o, e[9]);
         check("stall_valid", valid_o, 1);
         check("stall_ready", ready_o, 0);
      end
      ready_i = 1'b1;
      check("data", data_o, e[8:0]);
      check("zero", zero_o, e[9]);
      check("busy_ready", ready_o, 0);
      void'(exp_q.pop_front());
      @(posedge clk_i);
      #1;
      hs_cyc = cyc;
      check("post_hs_ready", ready_o, 1);
      check("post_hs_valid", valid_o, 0);
   endtask

   initial begin
      int prev;
      int cnt;
      int t;
      logic [7:0] ra, rb;
      logic [12:0] exp_w;

      rst_n_i = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      data1_i = '0;
      data2_i = '0;
      valid_w_i = 1'b0;
      ready_w_i = 1'b1;
      data1_w_i = '0;
      data2_w_i = '0;

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      check("rst_ready", ready_o, 1);
      check("rst_valid", valid_o, 0);
      check("rst_data", data_o, 9'h000);
      check("rst_zero", zero_o, 0);

      send(8'd200, 8'd55, 9'h091, 1'b0, 1'b0);
      receive(0);
      prev = acc_cyc;
      send(8'd55, 8'd200, 9'h16F, 1'b0, 1'b0);
      check("reaccept_spacing", acc_cyc - prev, 4);
      receive(0);

      send(8'h00, 8'hFF, 9'h101, 1'b0, 1'b0);
      receive(0);
      send(8'h80, 8'h80, 9'h000, 1'b1, 1'b0);
      receive(0);

      send(8'hA5, 8'h5A, 9'h04B, 1'b0, 1'b0);
      receive(5);
      send(8'hFF, 8'h00, 9'h0FF, 1'b0, 1'b1);
      receive(0);

      send(8'h01, 8'h02, 9'h1FF, 1'b0, 1'b0);
      @(negedge clk_i);
      rst_n_i = 1'b0;
      #1;
      check("midrst_ready", ready_o, 1);
      check("midrst_valid", valid_o, 0);
      check("midrst_data", data_o, 9'h000);
      check("midrst_zero", zero_o, 0);
      void'(exp_q.pop_back());
      @(negedge clk_i);
      rst_n_i = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         if (valid_o) cnt++;
      end
      check("midrst_no_valid", cnt, 0);
      check("midrst_idle", ready_o, 1);

      for (int i = 0; i < 4; i++) begin
         ra = 8'($urandom);
         rb = (i == 3) ? ra : 8'($urandom);
         send(ra, rb, {1'b0, ra} - {1'b0, rb}, ra == rb, 1'b0);
         receive(0);
      end

      @(negedge clk_i);
      data1_w_i = 12'h100;
      data2_w_i = 8'hFF;
      valid_w_i = 1'b1;
      exp_w = {1'b0, 12'h100} - {5'b0, 8'hFF};
      check("w_ready", ready_w_o, 1);
      @(posedge clk_i);
      #1;
      prev = cyc;
      valid_w_i = 1'b0;
      data1_w_i = 12'hFFF;
      t = 0;
      @(negedge clk_i);
      while (valid_w_o !== 1'b1 && t < 64) begin
         @(negedge clk_i);
         t++;
      end
      check("w_timeout", 32'(t < 64), 1);
      check("w_latency", cyc - prev, 3);
      check("w_data", data_w_o, exp_w);
      check("w_zero", zero_w_o, 0);
      @(posedge clk_i);
      #1;
      check("w_post_hs_ready", ready_w_o, 1);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
